// File: rtl/jtag_mem_master.sv
// Memory-access engine behind the JTAG shift stage. It turns each VALID read/write strobe into
// one req/gnt/rvalid transaction, using a one-entry command slot, a timeout and sticky error flags.
module jtag_mem_master #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF)
) (
  input  logic              TCK,
  input  logic              RESET,
  input  logic              VALID,
  input  logic [1:0]        OP,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] TO_MEM,
  output logic [DATA_W-1:0] FROM_MEM,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic              MEM_GNT,
  input  logic              MEM_RVALID,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              ERR_CLR,
  output logic              BUSY,
  output logic              ERR,
  output logic              OVERRUN
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_t      state, state_nxt;
  logic        slot_full, slot_full_nxt;
  cmd_t        slot, slot_nxt;
  logic [15:0] cnt, cnt_nxt, cnt_inc;
  logic [16:0] cnt_sum;

  logic              drain, cmd_ok, accept, drop, done, tmo_hit;
  logic              req_nxt, we_nxt, busy_nxt, err_nxt, ovr_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt, from_nxt;

  // The count is of cycles spent in REQ/RESP. It saturates so that a huge TIMEOUT can never wrap.
  assign cnt_sum = {1'b0, cnt} + 17'd1;
  assign cnt_inc = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

  assign drain   = (state == S_IDLE) && slot_full;
  assign cmd_ok  = VALID && (OP == 2'b01 || OP == 2'b10);
  assign accept  = cmd_ok && (!slot_full || drain);
  assign drop    = cmd_ok && !accept;
  assign done    = ((state == S_REQ) && MEM_GNT && MEM_RVALID) ||
                   ((state == S_RESP) && MEM_RVALID);
  assign tmo_hit = (state != S_IDLE) && !done && (cnt_inc >= TMO);

  // State register; every output is registered here too.
  always_ff @(posedge TCK) begin
    if (RESET) begin
      state     <= S_IDLE;
      slot_full <= 1'b0;
      slot      <= '0;
      cnt       <= '0;
      MEM_REQ   <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      FROM_MEM  <= '0;
      BUSY      <= 1'b0;
      ERR       <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      state     <= state_nxt;
      slot_full <= slot_full_nxt;
      slot      <= slot_nxt;
      cnt       <= cnt_nxt;
      MEM_REQ   <= req_nxt;
      MEM_WE    <= we_nxt;
      MEM_ADDR  <= addr_nxt;
      MEM_WDATA <= wdata_nxt;
      FROM_MEM  <= from_nxt;
      BUSY      <= busy_nxt;
      ERR       <= err_nxt;
      OVERRUN   <= ovr_nxt;
    end
  end

  // Next state. A same-edge response outranks the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (slot_full) state_nxt = S_REQ;
      S_REQ: begin
        if (done || tmo_hit) state_nxt = S_IDLE;
        else if (MEM_GNT)    state_nxt = S_RESP;
      end
      S_RESP: if (done || tmo_hit) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values for the datapath and outputs.
  always_comb begin
    slot_full_nxt = slot_full;
    slot_nxt      = slot;
    if (accept) begin
      slot_full_nxt = 1'b1;
      slot_nxt      = '{we: OP[1], addr: ADDR, data: TO_MEM};
    end else if (drain) begin
      slot_full_nxt = 1'b0;
    end

    req_nxt   = (state_nxt == S_REQ);
    we_nxt    = MEM_WE;
    addr_nxt  = MEM_ADDR;
    wdata_nxt = MEM_WDATA;
    cnt_nxt   = cnt;
    if (drain) begin
      we_nxt    = slot.we;
      addr_nxt  = slot.addr;
      wdata_nxt = slot.data;
      cnt_nxt   = '0;
    end else if (state != S_IDLE) begin
      cnt_nxt = cnt_inc;
    end

    from_nxt = FROM_MEM;
    if (done && !MEM_WE)         from_nxt = MEM_RDATA;
    else if (tmo_hit && !MEM_WE) from_nxt = ERR_DATA;

    err_nxt  = tmo_hit ? 1'b1 : (ERR_CLR ? 1'b0 : ERR);
    ovr_nxt  = drop    ? 1'b1 : (ERR_CLR ? 1'b0 : OVERRUN);
    busy_nxt = slot_full_nxt || (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_jtag_mem_master.sv
// Bench for jtag_mem_master. Directed cases cover reset, stalls, overrun, timeout and mid-transaction reset.
// A random phase follows, checked against a reference memory; a monitor scores every request issued.
module tb_jtag_mem_master;

  logic        TCK = 1'b0;
  logic        RESET, VALID, MEM_GNT, MEM_RVALID, ERR_CLR;
  logic [1:0]  OP;
  logic [31:0] ADDR, TO_MEM, MEM_RDATA;
  logic [31:0] FROM_MEM, MEM_ADDR, MEM_WDATA;
  logic        MEM_REQ, MEM_WE, BUSY, ERR, OVERRUN;

  jtag_mem_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) dut (
    .TCK(TCK), .RESET(RESET), .VALID(VALID), .OP(OP), .ADDR(ADDR), .TO_MEM(TO_MEM),
    .FROM_MEM(FROM_MEM), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_GNT(MEM_GNT), .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA),
    .ERR_CLR(ERR_CLR), .BUSY(BUSY), .ERR(ERR), .OVERRUN(OVERRUN));

  always #5 TCK = ~TCK;

  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } req_t;

  req_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic step();
    @(posedge TCK); #1;
  endtask

  task automatic pulse(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    VALID = 1'b1; OP = op; ADDR = a; TO_MEM = d;
    step();
    VALID = 1'b0; OP = 2'b00;
  endtask

  task automatic expect_req(input logic we, input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{we: we, addr: a, data: d});
  endtask

  // Memory responder. It grants after g cycles and responds r cycles after the grant (r=0 means the same edge).
  task automatic serve(input int g, input int r, input bit ovr, input logic [31:0] ovr_d);
    int n = 0;
    logic we;
    logic [31:0] a, d, rd;
    while (!MEM_REQ && n < 20) begin step(); n++; end
    if (!MEM_REQ) begin
      chk("serve_wait_req", 64'(MEM_REQ), 64'd1);
      return;
    end
    we = MEM_WE; a = MEM_ADDR; d = MEM_WDATA;
    rd = ovr ? ovr_d : (mem.exists(a) ? mem[a] : dflt(a));
    if (we) mem[a] = d;
    repeat (g) step();
    MEM_GNT = 1'b1;
    if (r == 0) begin MEM_RVALID = 1'b1; MEM_RDATA = rd; end
    step();
    MEM_GNT = 1'b0; MEM_RVALID = 1'b0;
    if (r > 0) begin
      repeat (r - 1) step();
      MEM_RVALID = 1'b1; MEM_RDATA = rd;
      step();
      MEM_RVALID = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (BUSY && n < 40) begin step(); n++; end
    chk(name, 64'(BUSY), 64'd0);
  endtask

  // Monitor: each new request is popped from the scoreboard and compared against it.
  initial begin
    logic prev = 1'b0;
    req_t e;
    forever begin
      @(negedge TCK);
      if (MEM_REQ && !prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_req", 64'(MEM_ADDR), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("req_we", 64'(MEM_WE), 64'(e.we));
          chk("req_addr", 64'(MEM_ADDR), 64'(e.addr));
          if (e.we) chk("req_wdata", 64'(MEM_WDATA), 64'(e.data));
        end
      end
      prev = MEM_REQ;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_from;
    int n;
    RESET = 1'b1; VALID = 1'b0; OP = 2'b00; ADDR = '0; TO_MEM = '0;
    MEM_GNT = 1'b0; MEM_RVALID = 1'b0; MEM_RDATA = '0; ERR_CLR = 1'b0;
    step();
    RESET = 1'b0;
    chk("rst_outs", {MEM_REQ, MEM_WE, BUSY, ERR, OVERRUN, FROM_MEM}, '0);
    chk("rst_addr", {MEM_ADDR, MEM_WDATA}, '0);

    // A nop leaves the engine idle.
    pulse(2'b00, 32'h10, 32'h0);
    step(); step();
    chk("nop_busy", {BUSY, MEM_REQ}, '0);

    // Zero-wait read. Latency: slot full at E, request at E+1, data at E+3.
    expect_req(1'b0, 32'h1000, 32'h0);
    pulse(2'b01, 32'h1000, 32'h0);
    chk("zw_busyE", {BUSY, MEM_REQ}, 64'b10);
    step();
    chk("zw_req", {MEM_REQ, MEM_WE, MEM_ADDR}, {2'b10, 32'h1000});
    MEM_GNT = 1'b1;
    step();
    MEM_GNT = 1'b0;
    chk("zw_req_1cyc", 64'(MEM_REQ), 64'd0);
    MEM_RVALID = 1'b1; MEM_RDATA = 32'hCAFEF00D;
    step();
    MEM_RVALID = 1'b0;
    chk("zw_data", 64'(FROM_MEM), 64'hCAFEF00D);
    chk("zw_busy", 64'(BUSY), 64'd0);

    // Write whose grant arrives 5 cycles late; the request must hold steady throughout.
    expect_req(1'b1, 32'h2000, 32'h55AA55AA);
    pulse(2'b10, 32'h2000, 32'h55AA55AA);
    step();
    for (int i = 0; i < 6; i++) begin
      chk("wr_stable", {MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA[29:0]},
          {2'b11, 32'h2000, 30'h15AA55AA});
      if (i == 5) MEM_GNT = 1'b1;
      step();
    end
    MEM_GNT = 1'b0;
    MEM_RVALID = 1'b1; MEM_RDATA = 32'h0BAD0BAD;
    step();
    MEM_RVALID = 1'b0;
    chk("wr_from_keep", 64'(FROM_MEM), 64'hCAFEF00D);
    chk("wr_busy", 64'(BUSY), 64'd0);

    // Three reads two cycles apart while the grant stalls: the third read is dropped.
    expect_req(1'b0, 32'hA0, 32'h0);
    expect_req(1'b0, 32'hB0, 32'h0);
    pulse(2'b01, 32'hA0, 32'h0);
    step();
    pulse(2'b01, 32'hB0, 32'h0);
    step();
    pulse(2'b01, 32'hC0, 32'h0);
    chk("ovr_set", 64'(OVERRUN), 64'd1);
    serve(0, 1, 1'b1, 32'h1111_0001);
    serve(0, 1, 1'b1, 32'h2222_0002);
    chk("ovr_last_data", 64'(FROM_MEM), 64'h2222_0002);
    chk("ovr_sticky", 64'(OVERRUN), 64'd1);
    ERR_CLR = 1'b1; step(); ERR_CLR = 1'b0;
    chk("ovr_clr", 64'(OVERRUN), 64'd0);
    chk("ovr_idle", 64'(BUSY), 64'd0);

    // A command that arrives on the same edge the slot drains is accepted.
    expect_req(1'b0, 32'hD0, 32'h0);
    expect_req(1'b1, 32'hE0, 32'h77);
    pulse(2'b01, 32'hD0, 32'h0);
    pulse(2'b10, 32'hE0, 32'h77);
    serve(1, 0, 1'b1, 32'h3333_0003);
    serve(0, 2, 1'b1, 32'h0);
    chk("drain_no_ovr", 64'(OVERRUN), 64'd0);
    chk("drain_data", 64'(FROM_MEM), 64'h3333_0003);

    // Read timeout with TIMEOUT=8 and no grant: the request is held for exactly 8 cycles.
    expect_req(1'b0, 32'hF0, 32'h0);
    pulse(2'b01, 32'hF0, 32'h0);
    n = 0;
    while (!MEM_REQ && n < 20) begin step(); n++; end
    n = 0;
    while (MEM_REQ && n < 50) begin step(); n++; end
    chk("tmo_req_cycles", 64'(n), 64'd8);
    chk("tmo_err", {ERR, BUSY}, 64'b10);
    chk("tmo_data", 64'(FROM_MEM), 64'hDEADBEEF);
    MEM_RVALID = 1'b1; MEM_RDATA = 32'h12345678;
    step();
    MEM_RVALID = 1'b0;
    chk("tmo_late_rvalid", 64'(FROM_MEM), 64'hDEADBEEF);
    ERR_CLR = 1'b1; step(); ERR_CLR = 1'b0;
    chk("err_clr", 64'(ERR), 64'd0);

    // Reset asserted during RESP; a later response must be ignored.
    expect_req(1'b0, 32'h3000, 32'h0);
    pulse(2'b01, 32'h3000, 32'h0);
    n = 0;
    while (!MEM_REQ && n < 20) begin step(); n++; end
    MEM_GNT = 1'b1; step(); MEM_GNT = 1'b0;
    RESET = 1'b1; step(); RESET = 1'b0;
    chk("rstmid_outs", {MEM_REQ, BUSY, FROM_MEM}, '0);
    MEM_RVALID = 1'b1; MEM_RDATA = 32'h0BADF00D;
    step();
    MEM_RVALID = 1'b0;
    chk("rstmid_from", {BUSY, FROM_MEM}, '0);

    // Random phase, run against the reference memory.
    exp_from = '0;
    for (int k = 0; k < 40; k++) begin
      logic [1:0]  op;
      logic [31:0] a, d;
      op = 2'($urandom_range(0, 3));
      a  = 32'h4000 + 32'($urandom_range(0, 7) * 4);
      d  = $urandom;
      if (op == 2'b01) begin
        exp_from = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
        expect_req(1'b0, a, d);
      end else if (op == 2'b10) begin
        ref_mem[a] = d;
        expect_req(1'b1, a, d);
      end
      pulse(op, a, d);
      if (op == 2'b01 || op == 2'b10)
        serve($urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 32'h0);
      else
        repeat (2) step();
      wait_idle("rnd_idle");
      chk("rnd_from", 64'(FROM_MEM), 64'(exp_from));
      repeat ($urandom_range(0, 2)) step();
    end
    chk("rnd_no_err", {ERR, OVERRUN}, '0);
    step(); step();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtag_mem_master.md
# jtag_mem_master

Memory-access engine that sits directly downstream of the JTAG shift/capture stage. Each `VALID` pulse with `OP`/`ADDR`/`TO_MEM` becomes exactly one transaction on a request/grant/response memory port. Read data is returned on `FROM_MEM` before the upstream stage finishes shifting the next 32-bit word. A one-entry command slot absorbs back-to-back pulses. Timeout and overrun conditions are reported through sticky status bits.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 255, max cycles from first `MEM_REQ` to `MEM_RVALID`; valid range 1..65535
- `ERR_DATA`, 32'hDEADBEEF, value loaded into `FROM_MEM` on a read timeout
- `TCK` input 1: clock; the upstream stage and the memory port both run on it
- `RESET` input 1: reset, synchronous, active-high
- `VALID` input 1: single-cycle command strobe from upstream
- `OP` input 2: 00 nop, 01 read, 10 write, 11 reserved (treated as nop)
- `ADDR` input ADDR_W: command address
- `TO_MEM` input DATA_W: write data
- `FROM_MEM` output DATA_W: last read data
- `MEM_REQ` output 1: request
- `MEM_WE` output 1: 1 = write
- `MEM_ADDR` output ADDR_W: request address
- `MEM_WDATA` output DATA_W: request write data
- `MEM_GNT` input 1: request accepted
- `MEM_RVALID` input 1: response valid (sent for reads and writes)
- `MEM_RDATA` input DATA_W: read response data
- `ERR_CLR` input 1: clears `ERR` and `OVERRUN`
- `BUSY` output 1: slot occupied or transaction outstanding
- `ERR` output 1: sticky, timeout occurred
- `OVERRUN` output 1: sticky, command dropped

## Operation
- **Command slot (1 entry):** captures `{OP, ADDR, TO_MEM}` at an edge where `VALID`=1, `OP` is 01 or 10, and the slot is empty or being drained in the same cycle. A valid command that finds the slot full and not draining is dropped and sets `OVERRUN`. Nop and reserved ops never touch the slot.
- **FSM states:**
  - `IDLE`: if the slot is full, drive `MEM_REQ`=1, `MEM_WE`, `MEM_ADDR`, `MEM_WDATA` from the slot, free the slot, go to `REQ`.
  - `REQ`: hold `MEM_REQ` and all request fields stable until an edge with `MEM_GNT`=1, then drop `MEM_REQ` and go to `RESP`. If `MEM_RVALID`=1 on that same edge, complete immediately and go to `IDLE`.
  - `RESP`: on `MEM_RVALID`=1, complete and go to `IDLE`. On a read, `FROM_MEM` <= `MEM_RDATA`; on a write, `MEM_RDATA` is ignored.
- **Timeout:** a counter clears on entry to `REQ` and increments every cycle in `REQ`/`RESP`. When it reaches `TIMEOUT` without completion: drop `MEM_REQ`, set `ERR`, load `FROM_MEM` <= `ERR_DATA` for reads, go to `IDLE`. Counter width is 16 bits and it saturates.
- **Stray responses:** `MEM_RVALID` in `IDLE` or `REQ` (without `GNT`) is ignored.
- **Status:** `BUSY` = slot full OR state != `IDLE`. `ERR_CLR` clears `ERR`/`OVERRUN`; a set event in the same cycle wins.
- **Reset:** `RESET` overrides everything, including mid-transaction. `MEM_REQ` drops at the reset edge and any later `GNT`/`RVALID` is ignored.

## Timing
- Reset values: `MEM_REQ`=0, `MEM_WE`=0, `MEM_ADDR`=0, `MEM_WDATA`=0, `FROM_MEM`=0, `BUSY`=0, `ERR`=0, `OVERRUN`=0, FSM=`IDLE`, slot empty, counter 0.
- Latency: `VALID` sampled at edge E → slot full after E → `MEM_REQ`=1 after E+1.
- With `GNT` and `RVALID` both zero-wait: read data on `FROM_MEM` after E+3, far below the 32-cycle word period.
- Completion and the next `IDLE` dispatch take separate cycles: at least one `MEM_REQ`=0 cycle between transactions.
- `VALID` on the cycle the slot drains (`IDLE`→`REQ`) is accepted, not dropped.
- All outputs are registered; no combinational path from `MEM_GNT`/`MEM_RVALID` to any output.

## Test plan
- **Reset:** `RESET` 1 cycle → all outputs 0; `VALID` with `OP`=00 → no `MEM_REQ`, `BUSY`=0.
- **Zero-wait read:** read `ADDR`=0x1000, memory returns 0xCAFEF00D one cycle after `GNT` → `MEM_REQ` high exactly 1 cycle at E+1 with `MEM_WE`=0 and `MEM_ADDR`=0x1000; `FROM_MEM`=0xCAFEF00D; `BUSY` low after completion.
- **Write with stalled grant:** write 0x55AA55AA to 0x2000, `GNT` delayed 5 cycles → `MEM_REQ`/`MEM_WE`/`MEM_WDATA` stable for 6 cycles; `FROM_MEM` unchanged.
- **Back-to-back and overrun:** three `VALID` reads 2 cycles apart with `GNT` stalled → the first two execute in order; the third is dropped and `OVERRUN`=1; `ERR_CLR` → `OVERRUN`=0.
- **Read timeout:** `TIMEOUT`=8, no `RVALID` → `MEM_REQ` drops, `ERR`=1, `FROM_MEM`=0xDEADBEEF; a late `RVALID` with 0x12345678 leaves `FROM_MEM` unchanged.
- **Reset mid-transaction:** `RESET` asserted while in `RESP` → `MEM_REQ`=0 and `BUSY`=0 next cycle; a following `RVALID` does not update `FROM_MEM`.
